multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
// PURPOSE
//  Next-generation register file for the Hubris core. Adds a configurable number of
//  read and write ports, an asynchronously cleared array, hardwired-zero register
//  support and a per-register pending (scoreboard) table.
//  Sits between decode/issue (reads, reservations) and write-back (writes), so that
//  dual-issue and multi-writeback pipelines can use it.
// PARAMETERS
//  REG_NUMBER      32                   number of architectural registers
//  REG_WIDTH       32                   data bits per register
//  REG_ADDR_WIDTH  $clog2(REG_NUMBER)   address width
//  READ_PORTS      2                    combinational read ports
//  WRITE_PORTS     2                    synchronous write ports
//  ZERO_REG        1                    1: register 0 reads 0, never written or reserved
// PORTS
//  clk             in   1                          system clock, all state on posedge
//  reset           in   1                          asynchronous, active-high
//  read_addr       in   READ_PORTS*REG_ADDR_WIDTH  packed read addresses, port 0 in LSBs
//  read_data       out  READ_PORTS*REG_WIDTH       packed read data
//  read_ready      out  READ_PORTS                 1 = operand is final (not pending)
//  write_enable    in   WRITE_PORTS                per-port write strobe
//  write_addr      in   WRITE_PORTS*REG_ADDR_WIDTH packed write addresses
//  write_data      in   WRITE_PORTS*REG_WIDTH      packed write data
//  reserve_enable  in   1                          mark reserve_addr pending (issue)
//  reserve_addr    in   REG_ADDR_WIDTH             destination being issued
//  pending_vector  out  REG_NUMBER                 current pending bit per register
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all registers = 0, all pending bits = 0.
//    Hence read_data = 0, read_ready = all 1, pending_vector = 0. A write or reserve in
//    the same cycle as reset is dropped.
//  - Writes commit at posedge for every enabled port. If several ports target the same
//    address, the highest-index port wins. Writes to reg 0 are ignored when ZERO_REG=1.
//  - Pending table: reserve_enable sets pending[reserve_addr] at posedge. Any enabled
//    write clears pending[write_addr].
//    Same-cycle reserve and write to the same register: the reserve wins (bit stays 1,
//    new producer in flight). Reserve of reg 0 with ZERO_REG=1 is ignored.
//  - Reads are combinational, zero latency. Register 0 (ZERO_REG=1) returns data 0 and
//    ready 1, regardless of writes.
//  - Otherwise: read_data = array[addr], read_ready = ~pending[addr], unless bypass
//    applies (see CONFIGURATION).
//  - Out-of-range addresses (REG_NUMBER not a power of 2): read returns 0/ready 1;
//    write and reserve are ignored.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding.
//    - If a read address matches an enabled write port in the same cycle, read_data =
//      that port's write_data (highest matching index) and read_ready = 1.
//    - Reg 0 with ZERO_REG=1 is never forwarded.
//  REGFILE_BYPASS_EN undefined: no forwarding.
//    - Reads see the pre-edge array value and pending state.
//    - The written value is visible from the cycle after the edge.
// STRUCTURE
//  - Shared include regfile_defs.vh: default REG_NUMBER/REG_WIDTH, ZERO_REG_ADDR = 0,
//    port-count localparams and pack/unpack slice helper macros.
//  - Sub-module regfile_pending_table: holds the pending bits, set/clear/priority logic
//    and pending_vector. Instantiated once.
//  - Top level holds the data array, write priority and read/bypass muxes.
// TESTING
//  - Reset mid-run with regs 1..31 loaded -> every read = 0, read_ready = 1,
//    pending_vector = 0.
//  - Write port0 r5=0xAAAA and port1 r5=0x5555 in one cycle -> next cycle read r5 = 0x5555.
//  - Write r0=0xFFFFFFFF plus reserve r0 -> read r0 = 0, ready = 1, pending_vector[0] = 0.
//  - Reserve r7, then write r7=0x1234 two cycles later -> ready low for two cycles,
//    then high with 0x1234.
//  - Same cycle: reserve r9 and write r9=0x42 -> pending[9] stays 1, data = 0x42.
//  - With REGFILE_BYPASS_EN: write r3=0xBEEF while reading r3 -> same-cycle
//    read = 0xBEEF, ready = 1.
//    Without REGFILE_BYPASS_EN: same-cycle read = old value, 0xBEEF on the next cycle.

Source files
------------

// File: rtl/multiport_register_file_pkg.sv
// Shared defaults and address helpers for the multi-port register file and its pending table.
package multiport_register_file_pkg;

    localparam int DEFAULT_REG_NUMBER  = 32;
    localparam int DEFAULT_REG_WIDTH   = 32;
    localparam int DEFAULT_READ_PORTS  = 2;
    localparam int DEFAULT_WRITE_PORTS = 2;
    localparam int unsigned ZERO_REG_ADDR = 0;

    // True when addr names a register that holds state: in range and not the hardwired zero.
    function automatic logic addr_is_live(input int unsigned addr,
                                          input int unsigned reg_number,
                                          input logic        zero_reg);
        return (addr < reg_number) && !(zero_reg && (addr == ZERO_REG_ADDR));
    endfunction

endpackage

// File: rtl/regfile_pending_table.sv
// Per-register pending (scoreboard) bits: set on reserve at issue, cleared by write-back.
module regfile_pending_table
    import multiport_register_file_pkg::*;
#(
    parameter int REG_NUMBER     = DEFAULT_REG_NUMBER,
    parameter int REG_ADDR_WIDTH = $clog2(REG_NUMBER),
    parameter int WRITE_PORTS    = DEFAULT_WRITE_PORTS,
    parameter int ZERO_REG       = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WRITE_PORTS-1:0]                write_enable,
    input  logic [WRITE_PORTS*REG_ADDR_WIDTH-1:0] write_addr,
    input  logic                                  reserve_enable,
    input  logic [REG_ADDR_WIDTH-1:0]             reserve_addr,
    output logic [REG_NUMBER-1:0]                 pending_vector
);

    logic [REG_NUMBER-1:0] pending;
    logic [REG_NUMBER-1:0] pending_next;

    always_comb begin
        // NOTE: every bit gets a default before the conditional updates, so no latch is inferred.
        pending_next = pending;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (write_enable[w] &&
                addr_is_live(32'(write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]), REG_NUMBER, ZERO_REG != 0))
                pending_next[write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b0;
        end
        // A newly issued producer outranks an older one completing in the same cycle.
        if (reserve_enable && addr_is_live(32'(reserve_addr), REG_NUMBER, ZERO_REG != 0))
            pending_next[reserve_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= pending_next;
    end

    assign pending_vector = pending;

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port register file with hardwired zero register and pending table.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int REG_NUMBER     = DEFAULT_REG_NUMBER,
    parameter int REG_WIDTH      = DEFAULT_REG_WIDTH,
    parameter int REG_ADDR_WIDTH = $clog2(REG_NUMBER),
    parameter int READ_PORTS     = DEFAULT_READ_PORTS,
    parameter int WRITE_PORTS    = DEFAULT_WRITE_PORTS,
    parameter int ZERO_REG       = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0]  read_addr,
    output logic [READ_PORTS*REG_WIDTH-1:0]       read_data,
    output logic [READ_PORTS-1:0]                 read_ready,
    input  logic [WRITE_PORTS-1:0]                write_enable,
    input  logic [WRITE_PORTS*REG_ADDR_WIDTH-1:0] write_addr,
    input  logic [WRITE_PORTS*REG_WIDTH-1:0]      write_data,
    input  logic                                  reserve_enable,
    input  logic [REG_ADDR_WIDTH-1:0]             reserve_addr,
    output logic [REG_NUMBER-1:0]                 pending_vector
);

    logic [REG_WIDTH-1:0]  regs [REG_NUMBER];
    logic [REG_NUMBER-1:0] pending;

    regfile_pending_table #(
        .REG_NUMBER     (REG_NUMBER),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .WRITE_PORTS    (WRITE_PORTS),
        .ZERO_REG       (ZERO_REG)
    ) u_pending (
        .clk            (clk),
        .reset          (reset),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .reserve_enable (reserve_enable),
        .reserve_addr   (reserve_addr),
        .pending_vector (pending)
    );

    assign pending_vector = pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is cleared asynchronously, which forces flops rather than a RAM macro.
            for (int i = 0; i < REG_NUMBER; i++)
                regs[i] <= '0;
        end else begin
            // NOTE: ports are scanned upward and the last non-blocking assignment wins, so the highest port has priority.
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (write_enable[w] &&
                    addr_is_live(32'(write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]), REG_NUMBER, ZERO_REG != 0))
                    regs[write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <= write_data[w*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_comb begin
        read_data  = '0;
        read_ready = '1;
        for (int r = 0; r < READ_PORTS; r++) begin
            if (addr_is_live(32'(read_addr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]), REG_NUMBER, ZERO_REG != 0)) begin
                read_data[r*REG_WIDTH +: REG_WIDTH] = regs[read_addr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
                read_ready[r] = ~pending[read_addr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (write_enable[w] &&
                        write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == read_addr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
                        read_data[r*REG_WIDTH +: REG_WIDTH] = write_data[w*REG_WIDTH +: REG_WIDTH];
                        read_ready[r] = 1'b1;
                    end
                end
`else
                // Without forwarding, reads see only the pre-edge array and pending state.
`endif
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: expected reads queued at stimulus time, drained by each test.
module tb_multiport_register_file;

    localparam int NREG = 32;
    localparam int W    = 32;
    localparam int AW   = 5;
    localparam int RP   = 2;
    localparam int WP   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [RP*AW-1:0] read_addr;
    logic [RP*W-1:0]  read_data;
    logic [RP-1:0]    read_ready;
    logic [WP-1:0]    write_enable;
    logic [WP*AW-1:0] write_addr;
    logic [WP*W-1:0]  write_data;
    logic             reserve_enable;
    logic [AW-1:0]    reserve_addr;
    logic [NREG-1:0]  pending_vector;

    typedef struct {
        string       tag;
        int          port;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          ready;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multiport_register_file #(
        .REG_NUMBER     (NREG),
        .REG_WIDTH      (W),
        .REG_ADDR_WIDTH (AW),
        .READ_PORTS     (RP),
        .WRITE_PORTS    (WP),
        .ZERO_REG       (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .read_ready     (read_ready),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .reserve_enable (reserve_enable),
        .reserve_addr   (reserve_addr),
        .pending_vector (pending_vector)
    );

    task automatic idle();
        write_enable   = '0;
        reserve_enable = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic put_write(input int p, input int a, input logic [W-1:0] d);
        write_enable[p]        = 1'b1;
        write_addr[p*AW +: AW] = AW'(a);
        write_data[p*W +: W]   = d;
    endtask

    task automatic put_reserve(input int a);
        reserve_enable = 1'b1;
        reserve_addr   = AW'(a);
    endtask

    task automatic push(input string tag, input int p, input int a, input logic [W-1:0] d, input logic r);
        exp_t e;
        e.tag = tag; e.port = p; e.addr = AW'(a); e.data = d; e.ready = r;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        idle();
        read_addr = '0; write_addr = '0; write_data = '0; reserve_addr = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if (pending_vector !== '0) begin
            n_bad++; $display("FAIL reset_pending: got %h want 0", pending_vector);
        end
        push("reset_r0", 0, 0, '0, 1'b1);
        push("reset_r31", 1, 31, '0, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        // load r1..r31 two per cycle, reserve r10 on the last load
        @(posedge clk); #1;
        for (int i = 1; i < NREG; i += 2) begin
            put_write(0, i, 32'h0101_0101 * i);
            if (i + 1 < NREG) put_write(1, i + 1, 32'h0101_0101 * (i + 1));
            if (i + 2 >= NREG) put_reserve(10);
            tick();
        end
        push("load_r17", 0, 17, 32'h1111_1111, 1'b1);
        push("load_r10", 1, 10, 32'h0A0A_0A0A, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        // asynchronous assert mid-cycle
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (pending_vector !== '0) begin
            n_bad++; $display("FAIL midreset_pending: got %h want 0", pending_vector);
        end
        for (int i = 1; i < NREG; i++) push($sformatf("midreset_r%0d", i), i % 2, i, '0, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        // write and reserve while reset is held are dropped
        put_write(0, 4, 32'hDEAD_BEEF);
        put_reserve(12);
        tick();
        @(negedge clk) reset = 1'b0;
        #1;
        n_cmp++;
        if (pending_vector !== '0) begin
            n_bad++; $display("FAIL reset_drop_pending: got %h want 0", pending_vector);
        end
        push("reset_drop_r4", 0, 4, '0, 1'b1);
        push("reset_drop_r12", 1, 12, '0, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_priority();
        exp_t e;
        put_write(0, 5, 32'h0000_AAAA);
        put_write(1, 5, 32'h0000_5555);
        tick();
        put_write(0, 6, 32'h1111_0000);
        put_write(1, 8, 32'h2222_0000);
        tick();
        push("prio_r5", 0, 5, 32'h0000_5555, 1'b1);
        push("dual_r6", 1, 6, 32'h1111_0000, 1'b1);
        push("dual_r8", 0, 8, 32'h2222_0000, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        put_write(0, 0, 32'hFFFF_FFFF);
        put_write(1, 0, 32'hFFFF_FFFF);
        put_reserve(0);
        tick();
        n_cmp++;
        if (pending_vector !== '0) begin
            n_bad++; $display("FAIL zero_pending: got %h want 0", pending_vector);
        end
        push("zero_p0", 0, 0, '0, 1'b1);
        push("zero_p1", 1, 0, '0, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    task automatic test_reserve_latency();
        exp_t e;
        put_reserve(7);
        tick();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) put_write(0, 7, 32'h0000_1234);
`ifdef REGFILE_BYPASS_EN
            if (c == 1) push("resv_fwd_r7", 1, 7, 32'h0000_1234, 1'b1);
            else        push($sformatf("resv_wait%0d_r7", c), 1, 7, '0, 1'b0);
`else
            push($sformatf("resv_wait%0d_r7", c), 1, 7, '0, 1'b0);
`endif
            while (sb.size() != 0) begin
                e = sb.pop_front();
                read_addr[e.port*AW +: AW] = e.addr; #1;
                n_cmp += 2;
                if (read_data[e.port*W +: W] !== e.data) begin
                    n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
                end
                if (read_ready[e.port] !== e.ready) begin
                    n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
                end
            end
            tick();
        end
        n_cmp++;
        if (pending_vector[7] !== 1'b0) begin
            n_bad++; $display("FAIL resv_clear_pending7: got %b want 0", pending_vector[7]);
        end
        push("resv_done_r7", 1, 7, 32'h0000_1234, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    task automatic test_reserve_write_same_cycle();
        exp_t e;
        put_reserve(9);
        put_write(0, 9, 32'h0000_0042);
        tick();
        n_cmp++;
        if (pending_vector !== 32'h0000_0200) begin
            n_bad++; $display("FAIL same_pending: got %h want 00000200", pending_vector);
        end
        push("same_r9", 0, 9, 32'h0000_0042, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        put_write(1, 9, 32'h0000_0043);
        tick();
        n_cmp++;
        if (pending_vector !== '0) begin
            n_bad++; $display("FAIL same_clear_pending: got %h want 0", pending_vector);
        end
        push("same_clear_r9", 0, 9, 32'h0000_0043, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        put_write(0, 3, 32'h0000_1111);
        tick();
        put_write(1, 3, 32'h0000_BEEF);
`ifdef REGFILE_BYPASS_EN
        push("fwd_same_r3", 0, 3, 32'h0000_BEEF, 1'b1);
`else
        push("fwd_same_r3", 0, 3, 32'h0000_1111, 1'b1);
`endif
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
        tick();
        push("fwd_next_r3", 0, 3, 32'h0000_BEEF, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] d;
        // random data on consecutive cycles, alternating ports, into r11..r26
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            put_write(i % 2, 11 + i, d);
            push($sformatf("b2b_r%0d", 11 + i), (i / 2) % 2, 11 + i, d, 1'b1);
            tick();
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_addr[e.port*AW +: AW] = e.addr; #1;
            n_cmp += 2;
            if (read_data[e.port*W +: W] !== e.data) begin
                n_bad++; $display("FAIL %s data: got %h want %h", e.tag, read_data[e.port*W +: W], e.data);
            end
            if (read_ready[e.port] !== e.ready) begin
                n_bad++; $display("FAIL %s ready: got %b want %b", e.tag, read_ready[e.port], e.ready);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_priority();
        test_zero_reg();
        test_reserve_latency();
        test_reserve_write_same_cycle();
        test_forwarding();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
